extend_pipe: RTL and testbench

//  Parametrised, pipelined immediate extender for the pipelined ARM processor.

---
 rtl/extend_pipe_if.sv | 34 +++
 rtl/extend_pipe.sv | 140 ++++++++++++++
 tb/tb_extend_pipe.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/extend_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : extend_pipe_if
// Brief    : Request/response bundle for the pipelined immediate extender.
// Revision : 1.0
// ============================================================================
interface extend_pipe_if #(
    parameter int XLEN      = 32,
    parameter int ERR_CNT_W = 8
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           ImmSrc;
    logic [23:0]          Instr;
    logic                 CarryIn;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      ExtImm;
    logic                 ImmCarry;
    logic                 ImmErr;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output flush, in_valid, ImmSrc, Instr, CarryIn, out_ready,
        input  in_ready, out_valid, ExtImm, ImmCarry, ImmErr, err_count
    );

    modport slave (
        input  flush, in_valid, ImmSrc, Instr, CarryIn, out_ready,
        output in_ready, out_valid, ExtImm, ImmCarry, ImmErr, err_count
    );
endinterface
`default_nettype wire

// File: rtl/extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : extend_pipe
// Brief    : Two-stage valid/ready immediate extender with ARM rotated imm,
//            flush and a saturating illegal-mode counter.
// Revision : 1.0
// ============================================================================
module extend_pipe #(
    parameter int XLEN      = 32,
    parameter int ROT_EN    = 1,
    parameter int ERR_CNT_W = 8
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    extend_pipe_if.slave  bus
);

    logic                 r_s1_valid;
    logic [2:0]           r_s1_src;
    logic [23:0]          r_s1_instr;
    logic                 r_s1_cin;

    logic                 r_s2_valid;
    logic [XLEN-1:0]      r_s2_ext;
    logic                 r_s2_carry;
    logic                 r_s2_err;

    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_s2_adv;
    logic                 w_out_fire;
    logic [3:0]           w_rot;
    logic [4:0]           w_sh;
    logic [31:0]          w_imm32;
    logic [31:0]          w_rot32;
    logic [XLEN-1:0]      w_ext;
    logic                 w_carry;
    logic                 w_err;

    assign w_in_ready = ~r_s1_valid | ~r_s2_valid | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready & ~bus.flush;
    assign w_s2_adv   = r_s1_valid & (~r_s2_valid | bus.out_ready);
    assign w_out_fire = r_s2_valid & bus.out_ready;

    generate
        if (ROT_EN != 0) begin : g_rot
            assign w_rot = r_s1_instr[11:8];
        end else begin : g_norot
            assign w_rot = 4'd0;
        end
    endgenerate

    // Rotate right by 2*rot; a zero shift makes the left term vanish.
    assign w_sh    = {w_rot, 1'b0};
    assign w_imm32 = {24'd0, r_s1_instr[7:0]};
    assign w_rot32 = (w_imm32 >> w_sh) | (w_imm32 << (6'd32 - {1'b0, w_sh}));

    always_comb begin
        w_ext   = '0;
        w_carry = r_s1_cin;
        w_err   = 1'b0;
        case (r_s1_src)
            3'b000: begin
                w_ext = XLEN'(w_rot32);
                if (w_rot != 4'd0) begin
                    w_carry = w_rot32[31];
                end
            end
            3'b001:  w_ext = XLEN'(r_s1_instr[11:0]);
            3'b010:  w_ext = XLEN'($signed({r_s1_instr, 2'b00}));
            3'b011:  w_ext = XLEN'({r_s1_instr[11:8], r_s1_instr[3:0]});
            3'b100:  w_ext = XLEN'($signed(r_s1_instr[11:0]));
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_src   <= 3'd0;
            r_s1_instr <= 24'd0;
            r_s1_cin   <= 1'b0;
        end else begin
            if (bus.flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_accept) begin
                r_s1_valid <= 1'b1;
            end else if (w_s2_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (w_accept) begin
                r_s1_src   <= bus.ImmSrc;
                r_s1_instr <= bus.Instr;
                r_s1_cin   <= bus.CarryIn;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_ext   <= '0;
            r_s2_carry <= 1'b0;
            r_s2_err   <= 1'b0;
        end else begin
            if (bus.flush) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_adv) begin
                r_s2_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_s2_valid <= 1'b0;
            end
            if (w_s2_adv) begin
                r_s2_ext   <= w_ext;
                r_s2_carry <= w_carry;
                r_s2_err   <= w_err;
            end
        end
    end

    // A delivery in a flush cycle still counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
        end else if (w_out_fire && r_s2_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.ExtImm    = r_s2_ext;
    assign bus.ImmCarry  = r_s2_carry;
    assign bus.ImmErr    = r_s2_err;
    assign bus.err_count = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_extend_pipe
// Brief    : Randomized scoreboard bench for extend_pipe (rotating 32-bit and
//            non-rotating 48-bit instances driven in lockstep).
// Revision : 1.0
// ============================================================================
module tb_extend_pipe;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    extend_pipe_if #(.XLEN(32), .ERR_CNT_W(8)) bus  ();
    extend_pipe_if #(.XLEN(48), .ERR_CNT_W(4)) bus2 ();

    extend_pipe #(.XLEN(32), .ROT_EN(1), .ERR_CNT_W(8)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    extend_pipe #(.XLEN(48), .ROT_EN(0), .ERR_CNT_W(4)) u_dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    assign bus2.flush     = bus.flush;
    assign bus2.in_valid  = bus.in_valid;
    assign bus2.ImmSrc    = bus.ImmSrc;
    assign bus2.Instr     = bus.Instr;
    assign bus2.CarryIn   = bus.CarryIn;
    assign bus2.out_ready = bus.out_ready;

    typedef struct {
        logic [63:0] e1;
        logic [63:0] e2;
        logic        c1;
        logic        c2;
        logic        err;
        int          cyc;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   ecnt1    = 0;
    int   ecnt2    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: mode rules evaluated directly, rotation done one bit at a time.
    function automatic void ref_one(input logic [2:0] s, input logic [23:0] ins, input logic cin,
                                    input bit roten, output logic [63:0] ext,
                                    output logic carry, output logic err);
        int          r;
        logic [31:0] v;
        ext   = '0;
        carry = cin;
        err   = 1'b0;
        case (s)
            3'd0: begin
                r = roten ? int'(ins[11:8]) : 0;
                v = {24'd0, ins[7:0]};
                for (int i = 0; i < 2 * r; i++) v = {v[0], v[31:1]};
                ext = {32'd0, v};
                if (r != 0) carry = v[31];
            end
            3'd1:    ext = {52'd0, ins[11:0]};
            3'd2:    ext = {{38{ins[23]}}, ins, 2'b00};
            3'd3:    ext = {56'd0, ins[11:8], ins[3:0]};
            3'd4:    ext = {{52{ins[11]}}, ins[11:0]};
            default: err = 1'b1;
        endcase
    endfunction

    task automatic step(input bit v, input logic [2:0] s, input logic [23:0] ins, input logic c,
                        input bit ordy, input bit fl, output bit acc);
        ent_t e;
        bit   exp_rdy;
        bit   exp_ov;
        @(negedge clk);
        bus.in_valid  = v;
        bus.ImmSrc    = s;
        bus.Instr     = ins;
        bus.CarryIn   = c;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #4;
        exp_rdy = (q.size() < 2) || ordy;
        exp_ov  = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
        chk("in_ready",   64'(bus.in_ready),   64'(exp_rdy));
        chk("in_ready48", 64'(bus2.in_ready),  64'(exp_rdy));
        chk("out_valid",  64'(bus.out_valid),  64'(exp_ov));
        chk("out_valid48",64'(bus2.out_valid), 64'(exp_ov));
        if (exp_ov) begin
            chk("ExtImm",     64'(bus.ExtImm),    q[0].e1 & 64'h0000_0000_FFFF_FFFF);
            chk("ImmCarry",   64'(bus.ImmCarry),  64'(q[0].c1));
            chk("ImmErr",     64'(bus.ImmErr),    64'(q[0].err));
            chk("ExtImm48",   64'(bus2.ExtImm),   q[0].e2 & 64'h0000_FFFF_FFFF_FFFF);
            chk("ImmCarry48", 64'(bus2.ImmCarry), 64'(q[0].c2));
        end
        chk("err_count",   64'(bus.err_count),  64'(ecnt1));
        chk("err_count48", 64'(bus2.err_count), 64'(ecnt2));
        if (exp_ov && ordy) begin
            if (q[0].err) begin
                if (ecnt1 < 255) ecnt1++;
                if (ecnt2 < 15)  ecnt2++;
            end
            void'(q.pop_front());
        end
        if (fl) q.delete();
        acc = v && exp_rdy && !fl;
        if (acc) begin
            ref_one(s, ins, c, 1'b1, e.e1, e.c1, e.err);
            ref_one(s, ins, c, 1'b0, e.e2, e.c2, e.err);
            e.cyc = cyc;
            q.push_back(e);
        end
        cyc++;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid),  64'd0);
        chk({tag, "_ExtImm"},    64'(bus.ExtImm),     64'd0);
        chk({tag, "_ImmCarry"},  64'(bus.ImmCarry),   64'd0);
        chk({tag, "_ImmErr"},    64'(bus.ImmErr),     64'd0);
        chk({tag, "_err_count"}, 64'(bus.err_count),  64'd0);
        chk({tag, "_in_ready"},  64'(bus.in_ready),   64'd1);
        chk({tag, "_err48"},     64'(bus2.err_count), 64'd0);
    endtask

    initial begin
        bit          acc;
        logic [2:0]  p_src;
        logic [23:0] p_ins;
        logic        p_c;
        int          sent;

        bus.in_valid  = 1'b0;
        bus.ImmSrc    = 3'd0;
        bus.Instr     = 24'd0;
        bus.CarryIn   = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        #12;
        chk_reset("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // Directed modes, back to back with the consumer always ready.
        step(1'b1, 3'd0, 24'h0004FF, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 3'd0, 24'h0000A5, 1'b1, 1'b1, 1'b0, acc);
        step(1'b1, 3'd2, 24'hFFFFFE, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 3'd3, 24'h000A05, 1'b1, 1'b1, 1'b0, acc);
        step(1'b1, 3'd4, 24'h000800, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 3'd1, 24'h000FFF, 1'b1, 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 24'd0, 1'b0, 1'b1, 1'b0, acc);

        // Backpressure: consumer stalled for the first 5 cycles.
        sent  = 0;
        p_src = 3'($urandom_range(0, 4));
        p_ins = 24'($urandom);
        p_c   = 1'($urandom);
        for (int k = 0; k < 20 && sent < 4; k++) begin
            step(1'b1, p_src, p_ins, p_c, k >= 5, 1'b0, acc);
            if (acc) begin
                sent++;
                p_src = 3'($urandom_range(0, 4));
                p_ins = 24'($urandom);
                p_c   = 1'($urandom);
            end
        end
        chk("bp_sent", 64'(sent), 64'd4);
        for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 24'd0, 1'b0, 1'b1, 1'b0, acc);

        // Flush with two entries in flight plus a new request.
        step(1'b1, 3'd1, 24'h000123, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 3'd4, 24'h000FFF, 1'b1, 1'b0, 1'b0, acc);
        step(1'b1, 3'd0, 24'h0002AB, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 3'd3, 24'h000F0F, 1'b1, 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 24'd0, 1'b0, 1'b1, 1'b0, acc);

        // Random traffic with stalls, illegal modes and occasional flushes.
        p_src = 3'($urandom_range(0, 7));
        p_ins = 24'($urandom);
        p_c   = 1'($urandom);
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 3) != 0, p_src, p_ins, p_c,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, acc);
            if (acc) begin
                p_src = 3'($urandom_range(0, 7));
                p_ins = 24'($urandom);
                p_c   = 1'($urandom);
            end
        end
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 24'd0, 1'b0, 1'b1, 1'b0, acc);

        // Counter saturation: 300 illegal requests delivered.
        for (int k = 0; k < 300; k++)
            step(1'b1, 3'd5, 24'($urandom), 1'($urandom), 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 24'd0, 1'b0, 1'b1, 1'b0, acc);
        chk("err_sat",   64'(bus.err_count),  64'd255);
        chk("err_sat48", 64'(bus2.err_count), 64'd15);

        // Reset in the middle of a stream.
        for (int k = 0; k < 4; k++)
            step(1'b1, 3'd5, 24'($urandom), 1'b1, 1'b1, 1'b0, acc);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_reset("midrst");
        q.delete();
        ecnt1 = 0;
        ecnt2 = 0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++)
            step(1'b1, 3'($urandom_range(0, 7)), 24'($urandom), 1'($urandom), 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 24'd0, 1'b0, 1'b1, 1'b0, acc);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
